sigma_delta_multich_gen: RTL
============================

SIGMA_DELTA_MULTICH_GEN -- requirements
Module: sigma_delta_multich_gen

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent oscillator channels (1..8).
REQ-002 SHALL have parameter BITWIDTH, default 40, signed width of the oscillator state and coefficient words.
REQ-003 SHALL have parameter FRAC, default 32, number of fractional bits in kin (k = kin/2^FRAC).
REQ-004 SHALL have parameter AMP, default 2^30, seed amplitude and sigma-delta feedback magnitude.
REQ-005 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  NCH  per-channel run request.
REQ-008 SHALL have port kin  input  NCH*BITWIDTH  per-channel unsigned tuning coefficients; channel i occupies bits [i*BITWIDTH +: BITWIDTH].
REQ-009 SHALL have port kin_valid  input  NCH  per-channel coefficient-update request.
REQ-010 SHALL have port kin_ready  output  NCH  per-channel acceptance of an update.
REQ-011 SHALL have port sd_out  output  NCH  per-channel 1-bit sigma-delta stream.
REQ-012 SHALL have port running  output  NCH  per-channel high while the channel is in RUN.

Function
REQ-013 Each channel SHALL implement an FSM with states IDLE, SEED and RUN: IDLE->SEED when enable[i]=1; SEED->RUN after exactly 1 cycle; RUN->IDLE when enable[i]=0; SEED->IDLE when enable[i]=0.
REQ-014 SEED SHALL load x=AMP, y=0 and acc=0, and SHALL set k_act to the pending coefficient if one is held.
REQ-015 In RUN, each cycle SHALL compute y' = y + ((k_act*x) >>> FRAC), then x' = x - ((k_act*y') >>> FRAC), using full-precision products, arithmetic shift, and truncation to BITWIDTH.
REQ-016 The quantizer bit SHALL be b = (acc >= 0); acc' = acc + y' - (b ? AMP : -AMP); acc SHALL be BITWIDTH+2 bits signed; sd_out[i] SHALL be registered b, giving 1-cycle latency from acc.
REQ-017 kin_ready[i] SHALL be 1 when channel i holds no pending coefficient; kin_valid[i]&&kin_ready[i] SHALL capture kin slice i into the pending register and drop kin_ready[i] on the next cycle.
REQ-018 In IDLE or SEED, a pending coefficient SHALL transfer to k_act on the next cycle.
REQ-019 In RUN, a pending coefficient SHALL transfer to k_act only in the cycle where y<0 and y'>=0 (upward zero crossing); kin_ready[i] SHALL rise the cycle after the transfer.
REQ-020 A capture and a transfer in the same cycle SHALL keep the new capture pending and apply the old value.
REQ-021 In IDLE, x, y and acc SHALL hold their values, sd_out[i] SHALL be 0, and running[i] SHALL be 0.
REQ-022 Channels SHALL be fully independent; no channel's state SHALL affect another's.

Reset
REQ-023 Reset SHALL force every channel to IDLE with x=y=acc=0, k_act=0, and no pending coefficient, and SHALL set sd_out=0, running=0 and kin_ready=all-ones.
REQ-024 Reset asserted during RUN SHALL abort on the same edge; a pending coefficient SHALL be discarded.
REQ-025 Reset SHALL take priority over enable and kin_valid.

Configuration
REQ-026 Macro SDGEN_DITHER_EN defined SHALL give each channel a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 XOR i on reset and stepped every RUN cycle.
REQ-027 With SDGEN_DITHER_EN, the quantizer SHALL compare (acc + (sign-extended LFSR <<< (FRAC-16))) >= 0.
REQ-028 Without SDGEN_DITHER_EN, no LFSR SHALL be present and the quantizer SHALL follow REQ-016 exactly (bit-exact deterministic).

Verification
REQ-029 Reset held 3 cycles with enable=2'b11 -> sd_out=0, running=0, kin_ready=2'b11 throughout; RUN is entered 2 cycles after release.
REQ-030 Load kin=42949673 (k≈0.01) on channel 0, then enable -> y period 628±1 cycles, |y| peak within 1% of 2^30, sd_out mean over 6280 cycles within 0.5% of 0.5.
REQ-031 During RUN, load a new kin=85899346 -> kin_ready low until the first upward zero crossing, k_act changes exactly there, period becomes 314±1 cycles, and there is no y discontinuity.
REQ-032 Channel 0 at k≈0.01 and channel 1 at k≈0.02; toggle enable[1] mid-run -> channel 0 output is bit-identical to a solo run; channel 1 restarts from the seed.
REQ-033 Reset pulsed mid-RUN with an update pending -> all state returns to REQ-023 values; the pending kin is lost and kin_ready=1.
REQ-034 Same stimulus with and without SDGEN_DITHER_EN -> y/x sequences are identical, sd_out sequences differ, and means agree within 0.5%.

Source files
------------

// File: rtl/sigma_delta_multich_gen.sv
// Multi-channel sine oscillator (coupled-form recurrence) with first-order sigma-delta output.
// Optional dither: define SDGEN_DITHER_EN to add a per-channel 16-bit LFSR to the quantizer input.

module sdgen_lane #(
    parameter int     BITWIDTH = 40,
    parameter int     FRAC     = 32,
    parameter longint AMP      = 64'd1073741824
`ifdef SDGEN_DITHER_EN
    , parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [BITWIDTH-1:0] kin,
    input  logic                kin_valid,
    output logic                kin_ready,
    output logic                sd_out,
    output logic                running
);
    localparam int PW = 2*BITWIDTH + 1;
    localparam int AW = BITWIDTH + 2;
    localparam logic signed [BITWIDTH-1:0] AMP_X = BITWIDTH'(AMP);
    localparam logic signed [AW-1:0]       AMP_A = AW'(AMP);

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
    state_t state, state_n;

    logic signed [BITWIDTH-1:0] x, y, x_n, y_n;
    logic signed [AW-1:0]       acc, acc_n, q_in;
    logic        [BITWIDTH-1:0] k_act, pend;
    logic                       pend_vld, b, xing, capture, transfer;
    logic signed [PW-1:0]       k_ext, p_kx, p_ky;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (enable) state_n = SEED;
            SEED:    state_n = enable ? RUN : IDLE;
            RUN:     if (!enable) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        running   = (state == RUN);
        kin_ready = !pend_vld;
    end

    // Products kept at full precision; only the shifted result is truncated.
    assign k_ext = PW'($signed({1'b0, k_act}));
    assign p_kx  = k_ext * PW'(x);
    assign y_n   = y + BITWIDTH'(p_kx >>> FRAC);
    assign p_ky  = k_ext * PW'(y_n);
    assign x_n   = x - BITWIDTH'(p_ky >>> FRAC);

`ifdef SDGEN_DITHER_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (reset)             lfsr <= LFSR_SEED;
        else if (state == RUN) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign q_in = acc + (AW'($signed(lfsr)) <<< (FRAC - 16));
`else
    assign q_in = acc;
`endif

    assign b     = !q_in[AW-1];
    assign acc_n = acc + AW'(y_n) - (b ? AMP_A : -AMP_A);
    assign xing  = y[BITWIDTH-1] && !y_n[BITWIDTH-1];

    // Retuning mid-run waits for an upward zero crossing so the waveform stays continuous.
    assign capture  = kin_valid && !pend_vld;
    assign transfer = pend_vld && ((state == IDLE) || (state == SEED) ||
                                   (state == RUN && enable && xing));

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            acc      <= '0;
            k_act    <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            sd_out   <= 1'b0;
        end else begin
            if (transfer) k_act <= pend;
            if (capture) begin
                pend     <= kin;
                pend_vld <= 1'b1;
            end else if (transfer) begin
                pend_vld <= 1'b0;
            end
            sd_out <= 1'b0;
            case (state)
                SEED: begin
                    x   <= AMP_X;
                    y   <= '0;
                    acc <= '0;
                end
                RUN: if (enable) begin
                    x      <= x_n;
                    y      <= y_n;
                    acc    <= acc_n;
                    sd_out <= b;
                end
                default: ;
            endcase
        end
    end
endmodule

module sigma_delta_multich_gen #(
    parameter int     NCH      = 2,
    parameter int     BITWIDTH = 40,
    parameter int     FRAC     = 32,
    parameter longint AMP      = 64'd1073741824
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          enable,
    input  logic [NCH*BITWIDTH-1:0] kin,
    input  logic [NCH-1:0]          kin_valid,
    output logic [NCH-1:0]          kin_ready,
    output logic [NCH-1:0]          sd_out,
    output logic [NCH-1:0]          running
);
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        sdgen_lane #(
            .BITWIDTH (BITWIDTH),
            .FRAC     (FRAC),
            .AMP      (AMP)
`ifdef SDGEN_DITHER_EN
            , .LFSR_SEED(16'hACE1 ^ 16'(i))
`endif
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable[i]),
            .kin       (kin[i*BITWIDTH +: BITWIDTH]),
            .kin_valid (kin_valid[i]),
            .kin_ready (kin_ready[i]),
            .sd_out    (sd_out[i]),
            .running   (running[i])
        );
    end
endmodule
